// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_FLUSH     = 2'd3
  } icache_state_t;

  // Wide enough for any supported line address; the top keeps only ADDR_W-OFFSET_W bits.
  localparam int unsigned LINE_ADDR_MAX_W = 64;

  typedef struct packed {
    logic [LINE_ADDR_MAX_W-1:0] line_addr;
  } icache_mem_req_t;

  function automatic int unsigned offset_w(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int unsigned set_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned line_w,
                                        input int unsigned num_sets);
    return addr_w - set_w(num_sets) - offset_w(line_w);
  endfunction

  function automatic int unsigned way_w(input int unsigned num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU tracker per set using a recency matrix; row r bit j set means way r is newer than way j.
module cache_lru #(
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned SET_W    = 2,
  parameter int unsigned WAY_W    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SET_W-1:0] query_set,
  output logic [WAY_W-1:0] lru_way,
  input  logic             upd_en,
  input  logic [SET_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][NUM_WAYS-1:0] order_q, order_d;

  always_comb begin
    order_d = order_q;
    if (upd_en) begin
      for (int j = 0; j < NUM_WAYS; j++) begin
        order_d[upd_set][upd_way][j] = (WAY_W'(j) != upd_way);
      end
      for (int j = 0; j < NUM_WAYS; j++) begin
        order_d[upd_set][j][upd_way] = 1'b0;
      end
    end
  end

  // An all-zero row is never newer than anything; the lowest such way is the LRU one.
  always_comb begin
    lru_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (order_q[query_set][w] == '0) lru_way = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) order_q <= '0;
    else        order_q <= order_d;
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: 0-cycle hits, blocking miss with memory handshake, set-serial flush.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LINE_W   = 128,
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned NUM_WAYS = 2,
  localparam int unsigned OFFSET_W = offset_w(LINE_W),
  localparam int unsigned LA_W     = ADDR_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [LINE_W-1:0] rsp_data,
  output logic              rsp_bus_error,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [LA_W-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_bus_error
);

  localparam int unsigned SET_W = set_w(NUM_SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, LINE_W, NUM_SETS);
  localparam int unsigned WAY_W = way_w(NUM_WAYS);

  icache_state_t                      state_q, state_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q, valid_d;
  logic [SET_W-1:0]                   cnt_q, cnt_d;
  icache_mem_req_t                    mem_req_q, mem_req_d;
  logic [WAY_W-1:0]                   victim_q, victim_d;

  logic [TAG_W-1:0]  tag_q  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] data_q [NUM_SETS][NUM_WAYS];

  logic [LA_W-1:0]     req_line;
  logic [SET_W-1:0]    req_set, fill_set;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way, free_way, lru_way, victim_sel;
  logic                free_found;
  logic [LINE_W-1:0]   hit_data;
  logic                fill_we;
  logic                lru_upd_en;
  logic [SET_W-1:0]    lru_upd_set;
  logic [WAY_W-1:0]    lru_upd_way;
  logic                bits_unused;

  assign req_line = req_addr[ADDR_W-1:OFFSET_W];
  assign req_set  = req_line[SET_W-1:0];
  assign req_tag  = req_line[LA_W-1:SET_W];
  assign fill_set = mem_req_q.line_addr[SET_W-1:0];
  assign fill_tag = mem_req_q.line_addr[LA_W-1:SET_W];
  assign mem_req_addr = mem_req_q.line_addr[LA_W-1:0];
  assign bits_unused  = ^{mem_req_q.line_addr, req_addr[OFFSET_W-1:0]};

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    assign hit_vec[gi] = valid_q[req_set][gi] && (tag_q[req_set][gi] == req_tag);
  end

  assign hit = |hit_vec;

  always_comb begin
    hit_way    = '0;
    free_way   = '0;
    free_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        free_way   = WAY_W'(w);
        free_found = 1'b1;
      end
    end
  end

  assign victim_sel = free_found ? free_way : lru_way;
  assign hit_data   = data_q[req_set][hit_way];

  cache_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .SET_W    (SET_W),
    .WAY_W    (WAY_W)
  ) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .query_set (req_set),
    .lru_way   (lru_way),
    .upd_en    (lru_upd_en),
    .upd_set   (lru_upd_set),
    .upd_way   (lru_upd_way)
  );

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    victim_d      = victim_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_data      = hit_data;
    rsp_bus_error = 1'b0;
    flush_done    = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    lru_upd_en    = 1'b0;
    lru_upd_set   = req_set;
    lru_upd_way   = hit_way;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = !flush_req;
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (req_valid) begin
          if (hit) begin
            rsp_valid  = 1'b1;
            lru_upd_en = 1'b1;
          end else begin
            mem_req_d.line_addr           = '0;
            mem_req_d.line_addr[LA_W-1:0] = req_line;
            victim_d                      = victim_sel;
            state_d                       = ST_MISS_REQ;
          end
        end
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        rsp_data = mem_rsp_data;
        if (mem_rsp_valid) begin
          rsp_valid     = 1'b1;
          rsp_bus_error = mem_rsp_bus_error;
          state_d       = ST_IDLE;
          // A failed fill leaves the set untouched so the line is refetched next time.
          if (!mem_rsp_bus_error) begin
            fill_we                    = 1'b1;
            valid_d[fill_set][victim_q] = 1'b1;
            lru_upd_en                 = 1'b1;
            lru_upd_set                = fill_set;
            lru_upd_way                = victim_q;
          end
        end
      end
      ST_FLUSH: begin
        valid_d[cnt_q] = '0;
        cnt_d          = cnt_q + SET_W'(1);
        if (cnt_q == SET_W'(NUM_SETS - 1)) begin
          flush_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      cnt_q     <= '0;
      mem_req_q <= '0;
      victim_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      victim_q  <= victim_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_set][victim_q]  <= fill_tag;
      data_q[fill_set][victim_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed self-checking bench for icache_assoc (32-bit addr, 128-bit lines, 4 sets, 2 ways).
module tb_icache_assoc;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         rsp_bus_error;
  logic         flush_req;
  logic         flush_done;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         mem_rsp_bus_error;

  int tests_run    = 0;
  int tests_failed = 0;

  icache_assoc #(
    .ADDR_W   (32),
    .LINE_W   (128),
    .NUM_SETS (4),
    .NUM_WAYS (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_bus_error     (rsp_bus_error),
    .flush_req         (flush_req),
    .flush_done        (flush_done),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .mem_rsp_bus_error (mem_rsp_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(n);
    return {4{w}};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic [127:0] data, input logic err,
                         input int delay, input int stall, input logic flush_in_wait);
    logic [127:0] line;
    line = 128'(addr >> 4);
    req_valid = 1'b1;
    req_addr  = addr;
    #3;
    check_val("miss_no_rsp", rsp_valid, 1'b0);
    check_val("miss_ready", req_ready, 1'b1);
    check_val("miss_no_mreq_yet", mem_req_valid, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #3;
      check_val("stall_mreq_valid", mem_req_valid, 1'b1);
      check_val("stall_mreq_addr", mem_req_addr, line);
      check_val("stall_req_ready", req_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1'b1;
    #3;
    check_val("mreq_valid", mem_req_valid, 1'b1);
    check_val("mreq_addr", mem_req_addr, line);
    tick();
    mem_req_ready = 1'b0;
    if (flush_in_wait) flush_req = 1'b1;
    for (int i = 0; i < delay; i++) begin
      #3;
      check_val("wait_req_ready", req_ready, 1'b0);
      check_val("wait_no_rsp", rsp_valid, 1'b0);
      check_val("wait_no_mreq", mem_req_valid, 1'b0);
      tick();
    end
    mem_rsp_valid     = 1'b1;
    mem_rsp_data      = data;
    mem_rsp_bus_error = err;
    #3;
    check_val("fill_rsp_valid", rsp_valid, 1'b1);
    check_val("fill_rsp_data", rsp_data, data);
    check_val("fill_bus_error", rsp_bus_error, err);
    tick();
    mem_rsp_valid     = 1'b0;
    mem_rsp_bus_error = 1'b0;
    $display("[TB] miss addr=%h line=%h err=%0d", addr, line[27:0], err);
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [127:0] data);
    req_valid = 1'b1;
    req_addr  = addr;
    #3;
    check_val("hit_rsp_valid", rsp_valid, 1'b1);
    check_val("hit_rsp_data", rsp_data, data);
    check_val("hit_bus_error", rsp_bus_error, 1'b0);
    check_val("hit_no_mreq", mem_req_valid, 1'b0);
    tick();
    req_valid = 1'b0;
    $display("[TB] hit  addr=%h", addr);
  endtask

  task automatic do_flush(input logic [31:0] addr);
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_addr  = addr;
    #3;
    check_val("flush_req_ready", req_ready, 1'b0);
    check_val("flush_no_rsp", rsp_valid, 1'b0);
    tick();
    flush_req = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      check_val("flush_done", flush_done, (i == 3));
      check_val("flush_busy", req_ready, 1'b0);
      tick();
    end
    #3;
    check_val("flush_back_idle", req_ready, 1'b1);
    check_val("flush_done_low", flush_done, 1'b0);
    tick();
    $display("[TB] flush completed");
  endtask

  initial begin
    rst_n             = 1'b0;
    req_valid         = 1'b0;
    req_addr          = '0;
    flush_req         = 1'b0;
    mem_req_ready     = 1'b0;
    mem_rsp_valid     = 1'b0;
    mem_rsp_data      = '0;
    mem_rsp_bus_error = 1'b0;
    #2;
    check_val("rst_req_ready", req_ready, 1'b1);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_mreq_valid", mem_req_valid, 1'b0);
    check_val("rst_flush_done", flush_done, 1'b0);
    check_val("rst_mreq_addr", mem_req_addr, 28'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    check_val("post_rst_ready", req_ready, 1'b1);
    tick();

    // 1: cold miss then same-line hit
    do_miss(32'h0000_0100, pat(1), 1'b0, 3, 0, 1'b0);
    do_hit(32'h0000_0104, pat(1));

    // 4: flush with a simultaneous (would-hit) request; both lines then miss
    do_miss(32'h0000_0110, pat(2), 1'b0, 0, 0, 1'b0);
    do_flush(32'h0000_0100);
    do_miss(32'h0000_0100, pat(3), 1'b0, 1, 0, 1'b0);
    do_miss(32'h0000_0110, pat(4), 1'b0, 1, 0, 1'b0);
    do_hit(32'h0000_0110, pat(4));
    do_flush(32'h0000_0000);

    // 2: eviction in set 0
    do_miss(32'h0000_0000, pat(10), 1'b0, 1, 0, 1'b0);
    do_miss(32'h0000_0040, pat(11), 1'b0, 1, 0, 1'b0);
    do_hit(32'h0000_0000, pat(10));
    do_miss(32'h0000_0080, pat(12), 1'b0, 1, 0, 1'b0);
    do_hit(32'h0000_0000, pat(10));
    do_hit(32'h0000_0080, pat(12));
    do_miss(32'h0000_0040, pat(13), 1'b0, 1, 0, 1'b0);
    do_hit(32'h0000_0044, pat(13));

    // 3: bus error installs nothing
    do_miss(32'h0000_0200, pat(20), 1'b1, 1, 0, 1'b0);
    do_miss(32'h0000_0200, pat(21), 1'b0, 1, 0, 1'b0);
    do_hit(32'h0000_0200, pat(21));

    // 5: memory backpressure, flush deferred from MISS_WAIT
    do_miss(32'h0000_0300, pat(30), 1'b0, 2, 5, 1'b1);
    do_flush(32'h0000_0300);
    do_miss(32'h0000_0000, pat(31), 1'b0, 1, 0, 1'b0);

    // 6: async reset during MISS_WAIT
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    tick();
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    check_val("mw_req_ready", req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("arst_req_ready", req_ready, 1'b1);
    check_val("arst_mreq_valid", mem_req_valid, 1'b0);
    check_val("arst_mreq_addr", mem_req_addr, 28'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = pat(40);
    tick();
    tick();
    rst_n = 1'b1;
    #3;
    check_val("late_fill_ignored", rsp_valid, 1'b0);
    check_val("late_fill_no_mreq", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    $display("[TB] async reset in MISS_WAIT applied");
    do_miss(32'h0000_0000, pat(41), 1'b0, 1, 0, 1'b0);
    do_miss(32'h0000_0100, pat(42), 1'b0, 1, 0, 1'b0);
    do_hit(32'h0000_0104, pat(42));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
